// File: rtl/pixel_pkg.sv
// Shared pixel datapath defaults and types for the pixel capture register.
package pixel_pkg;

  localparam int unsigned PIXEL_WIDTH = 9;
  localparam int unsigned PIXEL_CNT_W = 10;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

endpackage : pixel_pkg

// File: rtl/pixel_capture_counter.sv
// Wrapping capture counter: advances by one on each enabled edge, async active-low reset.
module pixel_capture_counter
  import pixel_pkg::*;
#(
  parameter int unsigned CNT_W = PIXEL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wraps silently from all-ones back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : pixel_capture_counter

// File: rtl/pixel_register.sv
// Pixel sample capture register with valid, load pulse and capture count.
// Optional even-parity output enabled by defining PIXEL_REGISTER_PARITY_EN.
module pixel_register
  import pixel_pkg::*;
#(
  parameter int unsigned WIDTH = PIXEL_WIDTH,
  parameter int unsigned CNT_W = PIXEL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             read,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             load_pulse,
  output logic [CNT_W-1:0] capture_cnt
`ifdef PIXEL_REGISTER_PARITY_EN
  ,
  output logic             parity_out
`endif
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             valid_d;
  logic             pulse_q;
  logic             pulse_d;

  // Capture on read, otherwise hold; valid is sticky until reset.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    pulse_d = read;
    if (read) begin
      data_d  = data_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign load_pulse = pulse_q;

  pixel_capture_counter #(
    .CNT_W (CNT_W)
  ) u_capture_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (read),
    .cnt_o (capture_cnt)
  );

`ifdef PIXEL_REGISTER_PARITY_EN
  logic parity_q;
  logic parity_d;

  // Parity is computed from the incoming sample so it lands with data_out.
  always_comb begin
    parity_d = parity_q;
    if (read) begin
      parity_d = ^data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_out = parity_q;
`endif

endmodule : pixel_register

// File: tb/tb_pixel_register.sv
// Randomized self-checking bench for pixel_register against a behavioural model.
module tb_pixel_register;
  import pixel_pkg::*;

  localparam int unsigned W  = PIXEL_WIDTH;
  localparam int unsigned CW = PIXEL_CNT_W;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          read    = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [W-1:0]  data_out;
  logic          valid;
  logic          load_pulse;
  logic [CW-1:0] capture_cnt;
`ifdef PIXEL_REGISTER_PARITY_EN
  logic          parity_out;
`endif

  pixel_register #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read        (read),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid       (valid),
    .load_pulse  (load_pulse),
    .capture_cnt (capture_cnt)
`ifdef PIXEL_REGISTER_PARITY_EN
    ,
    .parity_out  (parity_out)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_pulse;
  int           m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_data"},  32'(data_out),    32'(m_data));
    check({tag, "_valid"}, 32'(valid),       32'(m_valid));
    check({tag, "_pulse"}, 32'(load_pulse),  32'(m_pulse));
    check({tag, "_cnt"},   32'(capture_cnt), 32'(m_cnt));
`ifdef PIXEL_REGISTER_PARITY_EN
    check({tag, "_par"},   32'(parity_out),  32'(m_valid ? ^m_data : 1'b0));
`endif
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_valid = 1'b0;
    m_pulse = 1'b0;
    m_cnt   = 0;
  endtask

  // One clock: drive at negedge, update model at posedge, check shortly after.
  task automatic step(input string tag, input logic rd, input logic [W-1:0] d, input bit glitch);
    @(negedge clk);
    read    = rd;
    data_in = d;
    @(posedge clk);
    if (rd) begin
      m_data  = d;
      m_valid = 1'b1;
      m_cnt   = (m_cnt + 1) % (1 << CW);
    end
    m_pulse = rd;
    #1;
    check_all(tag);
    if (glitch) begin
      data_in = W'($urandom);
      #1 data_in = W'($urandom);
      #1 data_in = W'($urandom);
    end
  endtask

  // Reset asserted mid-cycle with read held high; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    read    = 1'b1;
    data_in = W'($urandom);
    rst_n   = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    read  = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First capture after reset release, then hold while data_in moves.
    step("cap5", 1'b1, W'(5), 1'b0);
    check("cap5_exact", 32'(data_out), 32'd5);
    step("hold_a", 1'b0, W'(9),  1'b0);
    step("hold_b", 1'b0, W'(13), 1'b0);
    step("hold_c", 1'b0, W'(17), 1'b0);
    check("hold_exact", 32'(data_out), 32'd5);

    // Random traffic, with data_in glitching between edges.
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom), W'($urandom), i % 3 == 0);
    end

    // Sweep 1..800 with read toggling every edge.
    do_reset();
    for (int i = 1; i <= 800; i++) begin
      step("sweep", (i % 2) == 1, W'(i), 1'b0);
    end
    check("sweep_cnt", 32'(capture_cnt), 32'd400);

    // Back-to-back captures through the counter wrap.
    do_reset();
    for (int i = 0; i < (1 << CW); i++) begin
      step("wrap", 1'b1, W'($urandom), 1'b0);
    end
    check("wrap_cnt",   32'(capture_cnt), 32'd0);
    check("wrap_valid", 32'(valid),       32'd1);
    step("post_wrap", 1'b1, W'(7), 1'b0);
    check("post_wrap_cnt", 32'(capture_cnt), 32'd1);

`ifdef PIXEL_REGISTER_PARITY_EN
    step("par_1ff", 1'b1, W'(9'h1FF), 1'b0);
    check("par_1ff_exact", 32'(parity_out), 32'd1);
    step("par_003", 1'b1, W'(9'h003), 1'b0);
    check("par_003_exact", 32'(parity_out), 32'd0);
`endif

    // A capture of an unchanged value still counts and pulses.
    do_reset();
    step("zero_cap", 1'b1, W'(0), 1'b0);
    check("zero_cap_valid", 32'(valid), 32'd1);
    step("idle", 1'b0, W'($urandom), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pixel_register
